hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_if.sv | 29 ++
 rtl/hazard_unit.sv | 77 +++++++
 tb/tb_hazard_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_if.sv
// Pipeline hazard interface: stage register/control inputs and stall, flush,
// forward and multicycle status outputs.
interface hazard_unit_if;
    logic [3:0]  RA1D, RA2D, RA1E, RA2E;
    logic [3:0]  WA3E, WA3M, WA3W;
    logic        RegWriteM, RegWriteW, MemtoRegE, BranchTakenE;
    logic        PCSrcD, PCSrcE, PCSrcM, PCSrcW;
    logic        MulStartE, MulDoneE;
    logic        StallF, StallD, StallE, FlushD, FlushE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        MulBusy, MulTimeout;
    logic [15:0] StallCount, FlushCount;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
               RegWriteM, RegWriteW, MemtoRegE, BranchTakenE,
               PCSrcD, PCSrcE, PCSrcM, PCSrcW, MulStartE, MulDoneE,
        input  StallF, StallD, StallE, FlushD, FlushE, ForwardAE, ForwardBE,
               MulBusy, MulTimeout, StallCount, FlushCount
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
               RegWriteM, RegWriteW, MemtoRegE, BranchTakenE,
               PCSrcD, PCSrcE, PCSrcM, PCSrcW, MulStartE, MulDoneE,
        output StallF, StallD, StallE, FlushD, FlushE, ForwardAE, ForwardBE,
               MulBusy, MulTimeout, StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding, load-use and PC-write stalls, flushes, and a
// multicycle-unit wait FSM with a 63-cycle watchdog and saturating event counters.
module hazard_unit (
    input  logic          clk,
    input  logic          reset,
    hazard_unit_if.slave  hz
);
    typedef enum logic {IDLE, MUL_WAIT} state_t;

    state_t      state, state_nxt;
    logic [5:0]  wd;
    logic        wd_expired, mul_stall, ldr_stall, pc_wr_pending;
    logic        timeout;
    logic [15:0] stall_cnt, flush_cnt;

    // Memory-stage result wins over writeback: it is the younger write.
    function automatic logic [1:0] fwd_sel(input logic [3:0] ra);
        if (hz.RegWriteM && ra == hz.WA3M)      return 2'b10;
        else if (hz.RegWriteW && ra == hz.WA3W) return 2'b01;
        else                                    return 2'b00;
    endfunction

    assign hz.ForwardAE = fwd_sel(hz.RA1E);
    assign hz.ForwardBE = fwd_sel(hz.RA2E);

    assign ldr_stall     = hz.MemtoRegE && (hz.RA1D == hz.WA3E || hz.RA2D == hz.WA3E);
    assign pc_wr_pending = hz.PCSrcD || hz.PCSrcE || hz.PCSrcM;
    assign wd_expired    = (state == MUL_WAIT) && (wd == 6'd63);

    always_comb begin
        state_nxt = state;
        mul_stall = 1'b0;
        case (state)
            IDLE: begin
                if (hz.MulStartE && !hz.MulDoneE) begin
                    state_nxt = MUL_WAIT;
                    mul_stall = 1'b1;
                end
            end
            MUL_WAIT: begin
                if (hz.MulDoneE || wd_expired) state_nxt = IDLE;
                else                           mul_stall = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A held multicycle op freezes the pipe, so any pending flush waits for release.
    assign hz.StallF = ldr_stall || pc_wr_pending || mul_stall;
    assign hz.StallD = ldr_stall || mul_stall;
    assign hz.StallE = mul_stall;
    assign hz.FlushD = (pc_wr_pending || hz.PCSrcW || hz.BranchTakenE) && !mul_stall;
    assign hz.FlushE = (ldr_stall || hz.BranchTakenE) && !mul_stall;

    assign hz.MulBusy    = (state == MUL_WAIT);
    assign hz.MulTimeout = timeout;
    assign hz.StallCount = stall_cnt;
    assign hz.FlushCount = flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wd        <= 6'd0;
            timeout   <= 1'b0;
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            state <= state_nxt;
            // Held at zero while idle, so it is already clear on entry.
            if (state == IDLE) wd <= 6'd0;
            else               wd <= wd + 6'd1;
            if (wd_expired) timeout <= 1'b1;
            if (hz.StallF && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
            if (hz.FlushE && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: combinational vector table plus multicycle,
// watchdog, saturation and reset sequences.
module tb_hazard_unit;
    logic clk = 1'b0;
    logic reset;
    hazard_unit_if hz();

    hazard_unit dut (.clk(clk), .reset(reset), .hz(hz.slave));

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic       rwm, rww, mtr, bt, pcd, pce, pcm, pcw;
        logic [1:0] fa, fb;
        logic       sf, sd, se, fd, fe;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clr();
        hz.RA1D = 4'd0; hz.RA2D = 4'd0; hz.RA1E = 4'd0; hz.RA2E = 4'd0;
        hz.WA3E = 4'd0; hz.WA3M = 4'd0; hz.WA3W = 4'd0;
        hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.MemtoRegE = 1'b0; hz.BranchTakenE = 1'b0;
        hz.PCSrcD = 1'b0; hz.PCSrcE = 1'b0; hz.PCSrcM = 1'b0; hz.PCSrcW = 1'b0;
        hz.MulStartE = 1'b0; hz.MulDoneE = 1'b0;
    endtask

    // Advance one edge; inputs are then driven 1 time unit after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic stalls(input string nm, input logic f, input logic d, input logic e);
        chk({nm, ".StallF"}, {15'd0, hz.StallF}, {15'd0, f});
        chk({nm, ".StallD"}, {15'd0, hz.StallD}, {15'd0, d});
        chk({nm, ".StallE"}, {15'd0, hz.StallE}, {15'd0, e});
    endtask

    initial begin
        int n;
        tbl[0]  = '{4'd0,4'd0,4'd3,4'd5,4'd0,4'd3,4'd3, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[1]  = '{4'd0,4'd0,4'd3,4'd5,4'd0,4'd3,4'd3, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[2]  = '{4'd0,4'd0,4'd3,4'd5,4'd0,4'd5,4'd3, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,2'b10, 1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[3]  = '{4'd0,4'd0,4'd3,4'd5,4'd0,4'd5,4'd3, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[4]  = '{4'd4,4'd0,4'd0,4'd0,4'd4,4'd0,4'd0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00, 1'b1,1'b1,1'b0,1'b0,1'b1};
        tbl[5]  = '{4'd1,4'd2,4'd0,4'd0,4'd4,4'd0,4'd0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[6]  = '{4'd1,4'd2,4'd0,4'd0,4'd4,4'd0,4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'b00,2'b00, 1'b1,1'b0,1'b0,1'b1,1'b0};
        tbl[7]  = '{4'd1,4'd2,4'd0,4'd0,4'd4,4'd0,4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b00, 1'b0,1'b0,1'b0,1'b1,1'b0};
        tbl[8]  = '{4'd1,4'd2,4'd0,4'd0,4'd4,4'd0,4'd0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00, 1'b0,1'b0,1'b0,1'b1,1'b1};
        tbl[9]  = '{4'd4,4'd0,4'd0,4'd0,4'd4,4'd0,4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[10] = '{4'd0,4'd7,4'd0,4'd0,4'd7,4'd0,4'd0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 2'b00,2'b00, 1'b1,1'b1,1'b0,1'b1,1'b1};

        clr();
        reset = 1'b1;
        hz.RegWriteM = 1'b1; hz.WA3M = 4'd9; hz.RA1E = 4'd9;
        cyc();
        #1;
        chk("rst.fwd_follows", {14'd0, hz.ForwardAE}, 16'd2);
        chk("rst.MulBusy", {15'd0, hz.MulBusy}, 16'd0);
        chk("rst.MulTimeout", {15'd0, hz.MulTimeout}, 16'd0);
        chk("rst.StallCount", hz.StallCount, 16'd0);
        chk("rst.FlushCount", hz.FlushCount, 16'd0);
        reset = 1'b0;
        clr();

        for (int i = 0; i < 11; i++) begin
            hz.RA1D = tbl[i].ra1d; hz.RA2D = tbl[i].ra2d; hz.RA1E = tbl[i].ra1e; hz.RA2E = tbl[i].ra2e;
            hz.WA3E = tbl[i].wa3e; hz.WA3M = tbl[i].wa3m; hz.WA3W = tbl[i].wa3w;
            hz.RegWriteM = tbl[i].rwm; hz.RegWriteW = tbl[i].rww; hz.MemtoRegE = tbl[i].mtr;
            hz.BranchTakenE = tbl[i].bt; hz.PCSrcD = tbl[i].pcd; hz.PCSrcE = tbl[i].pce;
            hz.PCSrcM = tbl[i].pcm; hz.PCSrcW = tbl[i].pcw;
            #1;
            chk($sformatf("v%0d.ForwardAE", i), {14'd0, hz.ForwardAE}, {14'd0, tbl[i].fa});
            chk($sformatf("v%0d.ForwardBE", i), {14'd0, hz.ForwardBE}, {14'd0, tbl[i].fb});
            chk($sformatf("v%0d.StallF", i), {15'd0, hz.StallF}, {15'd0, tbl[i].sf});
            chk($sformatf("v%0d.StallD", i), {15'd0, hz.StallD}, {15'd0, tbl[i].sd});
            chk($sformatf("v%0d.StallE", i), {15'd0, hz.StallE}, {15'd0, tbl[i].se});
            chk($sformatf("v%0d.FlushD", i), {15'd0, hz.FlushD}, {15'd0, tbl[i].fd});
            chk($sformatf("v%0d.FlushE", i), {15'd0, hz.FlushE}, {15'd0, tbl[i].fe});
            cyc();
        end
        clr();

        // Load-use for one cycle bumps both counters once.
        do_reset();
        hz.MemtoRegE = 1'b1; hz.WA3E = 4'd4; hz.RA2D = 4'd4;
        #1;
        stalls("ldr", 1'b1, 1'b1, 1'b0);
        chk("ldr.FlushE", {15'd0, hz.FlushE}, 16'd1);
        cyc();
        clr();
        chk("ldr.StallCount", hz.StallCount, 16'd1);
        chk("ldr.FlushCount", hz.FlushCount, 16'd1);

        // Multicycle op completing at cycle 4.
        do_reset();
        hz.MulStartE = 1'b1;
        #1;
        stalls("mul.c0", 1'b1, 1'b1, 1'b1);
        chk("mul.c0.MulBusy", {15'd0, hz.MulBusy}, 16'd0);
        for (int c = 1; c <= 3; c++) begin
            cyc();
            stalls($sformatf("mul.c%0d", c), 1'b1, 1'b1, 1'b1);
            chk($sformatf("mul.c%0d.MulBusy", c), {15'd0, hz.MulBusy}, 16'd1);
        end
        cyc();
        hz.MulDoneE = 1'b1;
        #1;
        stalls("mul.c4", 1'b0, 1'b0, 1'b0);
        chk("mul.c4.MulBusy", {15'd0, hz.MulBusy}, 16'd1);
        cyc();
        clr();
        #1;
        chk("mul.c5.MulBusy", {15'd0, hz.MulBusy}, 16'd0);
        chk("mul.StallCount", hz.StallCount, 16'd4);

        // Branch during the wait: flushes held off until release.
        do_reset();
        hz.MulStartE = 1'b1;
        cyc();
        hz.BranchTakenE = 1'b1;
        #1;
        chk("brw.FlushD", {15'd0, hz.FlushD}, 16'd0);
        chk("brw.FlushE", {15'd0, hz.FlushE}, 16'd0);
        hz.MulDoneE = 1'b1;
        #1;
        chk("brd.FlushD", {15'd0, hz.FlushD}, 16'd1);
        chk("brd.FlushE", {15'd0, hz.FlushE}, 16'd1);
        cyc();
        clr();

        // Watchdog: expiry after 63 wait cycles.
        do_reset();
        hz.MulStartE = 1'b1;
        cyc();
        n = 0;
        while (hz.StallE && n < 100) begin
            cyc();
            n++;
        end
        chk("wd.release_cycles", n[15:0], 16'd63);
        chk("wd.exp.MulBusy", {15'd0, hz.MulBusy}, 16'd1);
        chk("wd.exp.MulTimeout", {15'd0, hz.MulTimeout}, 16'd0);
        hz.MulStartE = 1'b0;
        cyc();
        chk("wd.MulBusy", {15'd0, hz.MulBusy}, 16'd0);
        chk("wd.MulTimeout", {15'd0, hz.MulTimeout}, 16'd1);
        chk("wd.StallE", {15'd0, hz.StallE}, 16'd0);
        cyc();
        chk("wd.sticky", {15'd0, hz.MulTimeout}, 16'd1);

        // Saturation, then reset in the middle of a wait.
        hz.PCSrcD = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        chk("sat.StallCount", hz.StallCount, 16'hFFFF);
        hz.PCSrcD = 1'b0;
        hz.MulStartE = 1'b1;
        cyc();
        chk("rstw.MulBusy_pre", {15'd0, hz.MulBusy}, 16'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        hz.MulStartE = 1'b0;
        #1;
        chk("rstw.MulBusy", {15'd0, hz.MulBusy}, 16'd0);
        chk("rstw.StallCount", hz.StallCount, 16'd0);
        chk("rstw.MulTimeout", {15'd0, hz.MulTimeout}, 16'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
